lc3_controller: RTL and testbench

LC3_CONTROLLER -- requirements
Module: lc3_controller

---
 rtl/lc3_ctrl_pkg.sv | 20 ++
 rtl/lc3_hazard_detect.sv | 26 ++
 rtl/lc3_controller.sv | 132 +++++++++++++
 tb/tb_lc3_controller.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/lc3_ctrl_pkg.sv
// lc3_ctrl_pkg: opcodes, mem_state encoding and FSM states shared by the LC-3 controller
package lc3_ctrl_pkg;
  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;
  localparam logic [1:0] MS_RD   = 2'd0;
  localparam logic [1:0] MS_IND  = 2'd1;
  localparam logic [1:0] MS_WR   = 2'd2;
  localparam logic [1:0] MS_IDLE = 2'd3;
  typedef enum logic [2:0] {IDLE, FILL, RUN, MEM_RD, MEM_IND, MEM_WR, FLUSH} state_e;
endpackage

// File: rtl/lc3_hazard_detect.sv
// lc3_hazard_detect: RAW match of decode sources against the execute ALU result and the just-completed load
module lc3_hazard_detect
  import lc3_ctrl_pkg::*;
(
  input  logic [15:0] ir_i,
  input  logic [15:0] ir_exec_i,
  input  logic [2:0]  ld_dst_i,
  input  logic        ld_vld_i,
  output logic        alu_1_o,
  output logic        alu_2_o,
  output logic        mem_1_o,
  output logic        mem_2_o
);
  logic [3:0] op;
  logic rd_sr1, rd_sr2, x_alu, unused_bits;
  assign op = ir_i[15:12];
  assign rd_sr1 = op inside {OP_ADD, OP_AND, OP_NOT, OP_LDR, OP_STR, OP_JMP};
  assign rd_sr2 = (op == OP_ADD || op == OP_AND) && !ir_i[5];
  assign x_alu = ir_exec_i[15:12] inside {OP_ADD, OP_AND, OP_NOT, OP_LEA};
  assign alu_1_o = x_alu && rd_sr1 && ir_exec_i[11:9] == ir_i[8:6];
  assign alu_2_o = x_alu && rd_sr2 && ir_exec_i[11:9] == ir_i[2:0];
  // the ALU result is younger than the load, so it wins on a shared register
  assign mem_1_o = !alu_1_o && ld_vld_i && rd_sr1 && ld_dst_i == ir_i[8:6];
  assign mem_2_o = !alu_2_o && ld_vld_i && rd_sr2 && ld_dst_i == ir_i[2:0];
  assign unused_bits = ^{ir_i[11:9], ir_i[4:3], ir_exec_i[8:0]};
endmodule

// File: rtl/lc3_controller.sv
// lc3_controller: LC-3 pipeline control FSM (stage enables, memory phases, branch flush, forwarding)
// Define LC3_CTRL_BYPASS_EN for operand forwarding; otherwise a RAW match stalls one cycle.
module lc3_controller
  import lc3_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_instr,
  input  logic        complete_data,
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  input  logic [2:0]  NZP,
  input  logic [2:0]  psr,
  output logic        enable_updatePC,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        br_taken,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2,
  output logic        bypass_mem_1,
  output logic        bypass_mem_2,
  output logic [1:0]  mem_state
);
`ifdef LC3_CTRL_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  state_e state_q;
  logic [1:0] cnt_q, ms_q;
  logic [4:0] en_q;
  logic [3:0] byp_q, haz, op_x;
  logic [2:0] ld_dst_q;
  logic br_q, ld_q, ld_done_q, stall_q, is_ld, is_ind, is_mem, taken, stall, unused_psr;
  assign op_x = IR_Exec[15:12];
  assign is_ld = op_x inside {OP_LD, OP_LDR, OP_LDI};
  assign is_ind = op_x inside {OP_LDI, OP_STI};
  assign is_mem = is_ld || op_x inside {OP_ST, OP_STR, OP_STI};
  assign taken = (op_x == OP_BR && |(NZP & IR_Exec[11:9])) || op_x == OP_JMP;
  // stall_q limits a RAW stall to one cycle while the producer drains to writeback
  assign stall = !BYP && |haz && !stall_q;
  assign unused_psr = ^psr;
  assign {enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback} = en_q;
  assign {bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2} = byp_q;
  assign br_taken = br_q;
  assign mem_state = ms_q;
  lc3_hazard_detect u_haz (
    .ir_i      (IR),
    .ir_exec_i (IR_Exec),
    .ld_dst_i  (ld_dst_q),
    .ld_vld_i  (ld_done_q),
    .alu_1_o   (haz[3]),
    .alu_2_o   (haz[2]),
    .mem_1_o   (haz[1]),
    .mem_2_o   (haz[0])
  );
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      en_q      <= '0;
      byp_q     <= '0;
      br_q      <= 1'b0;
      ms_q      <= MS_IDLE;
      ld_q      <= 1'b0;
      ld_dst_q  <= '0;
      ld_done_q <= 1'b0;
      stall_q   <= 1'b0;
    end else begin
      br_q      <= 1'b0;
      byp_q     <= '0;
      ld_done_q <= 1'b0;
      stall_q   <= 1'b0;
      case (state_q)
        IDLE: if (complete_instr) begin
          state_q <= FILL;
          en_q    <= 5'b11000;
        end
        FILL: begin
          en_q[2] <= 1'b1;
          en_q[1] <= cnt_q != 2'd0;
          en_q[0] <= cnt_q == 2'd2;
          cnt_q   <= cnt_q == 2'd2 ? 2'd0 : cnt_q + 2'd1;
          if (cnt_q == 2'd2) state_q <= RUN;
        end
        RUN: begin
          en_q <= 5'b11111;
          ms_q <= MS_IDLE;
          if (is_mem) begin
            en_q     <= '0;
            state_q  <= is_ind ? MEM_IND : is_ld ? MEM_RD : MEM_WR;
            ms_q     <= is_ind ? MS_IND : is_ld ? MS_RD : MS_WR;
            ld_q     <= is_ld;
            ld_dst_q <= IR_Exec[11:9];
          end else if (taken) begin
            br_q    <= 1'b1;
            en_q    <= 5'b11001;
            state_q <= FLUSH;
          end else if (stall) begin
            stall_q <= 1'b1;
            en_q    <= 5'b00001;
          end else byp_q <= BYP ? haz : '0;
        end
        MEM_IND: if (complete_data) begin
          state_q <= ld_q ? MEM_RD : MEM_WR;
          ms_q    <= ld_q ? MS_RD : MS_WR;
        end
        MEM_RD: if (complete_data) begin
          state_q   <= RUN;
          en_q      <= 5'b11111;
          ms_q      <= MS_IDLE;
          ld_done_q <= 1'b1;
        end
        MEM_WR: if (complete_data) begin
          state_q <= RUN;
          en_q    <= 5'b11110;
          ms_q    <= MS_IDLE;
        end
        FLUSH: begin
          cnt_q <= cnt_q == 2'd0 ? 2'd1 : 2'd0;
          if (cnt_q != 2'd0) begin
            state_q <= RUN;
            en_q    <= 5'b11111;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lc3_controller.sv
// tb_lc3_controller: directed vector table plus hand sequences for fill, memory, flush and reset
module tb_lc3_controller;
  import lc3_ctrl_pkg::*;
`ifdef LC3_CTRL_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b0, complete_instr = 1'b0, complete_data = 1'b0;
  logic [15:0] IR = '0, IR_Exec = '0;
  logic [2:0] NZP = '0, psr = '0;
  logic enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback, br_taken;
  logic bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
  logic [1:0] mem_state;
  logic [4:0] en;
  logic [3:0] byp;
  int n_chk = 0, n_fail = 0;
  typedef struct packed {
    logic [15:0] ir_x;
    logic [15:0] ir;
    logic [2:0]  nzp;
    logic [3:0]  byp;
  } vec_t;
  vec_t tbl[12];
  assign en = {enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback};
  assign byp = {bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2};
  always #5 clock = ~clock;
  lc3_controller dut (
    .clock(clock), .reset(reset), .complete_instr(complete_instr), .complete_data(complete_data),
    .IR(IR), .IR_Exec(IR_Exec), .NZP(NZP), .psr(psr),
    .enable_updatePC(enable_updatePC), .enable_fetch(enable_fetch), .enable_decode(enable_decode),
    .enable_execute(enable_execute), .enable_writeback(enable_writeback), .br_taken(br_taken),
    .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2), .bypass_mem_1(bypass_mem_1),
    .bypass_mem_2(bypass_mem_2), .mem_state(mem_state)
  );
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic chk(input string nm, input logic [4:0] e, input logic b, input logic [3:0] y, input logic [1:0] m);
    cmp({nm, ".en"}, {11'b0, en}, {11'b0, e});
    cmp({nm, ".br"}, {15'b0, br_taken}, {15'b0, b});
    cmp({nm, ".byp"}, {12'b0, byp}, {12'b0, y});
    cmp({nm, ".ms"}, {14'b0, mem_state}, {14'b0, m});
  endtask
  initial begin
    tbl[0]  = '{16'h0000, 16'h0000, 3'b111, 4'b0000};
    tbl[1]  = '{16'h0405, 16'h0000, 3'b100, 4'b0000};
    tbl[2]  = '{16'h0805, 16'h0000, 3'b010, 4'b0000};
    tbl[3]  = '{16'h1261, 16'h1442, 3'b000, 4'b1000};
    tbl[4]  = '{16'h1261, 16'h1681, 3'b000, 4'b0100};
    tbl[5]  = '{16'h1261, 16'h1441, 3'b000, 4'b1100};
    tbl[6]  = '{16'h1261, 16'h16A1, 3'b000, 4'b0000};
    tbl[7]  = '{16'hE200, 16'h1442, 3'b000, 4'b1000};
    tbl[8]  = '{16'h947F, 16'h1442, 3'b000, 4'b0100};
    tbl[9]  = '{16'h1261, 16'h0240, 3'b000, 4'b0000};
    tbl[10] = '{16'h1A61, 16'h1442, 3'b000, 4'b0000};
    tbl[11] = '{16'h1261, 16'hC040, 3'b000, 4'b1000};
    tick; tick;
    chk("reset", 5'b00000, 1'b0, 4'b0000, MS_IDLE);
    reset = 1'b1;
    tick; tick;
    chk("idle_hold", 5'b00000, 1'b0, 4'b0000, MS_IDLE);
    complete_instr = 1'b1;
    tick;
    complete_instr = 1'b0;
    chk("fill1", 5'b11000, 1'b0, 4'b0000, MS_IDLE);
    tick;
    chk("fill2", 5'b11100, 1'b0, 4'b0000, MS_IDLE);
    tick;
    chk("fill3", 5'b11110, 1'b0, 4'b0000, MS_IDLE);
    tick;
    chk("fill4", 5'b11111, 1'b0, 4'b0000, MS_IDLE);
    for (int i = 0; i < 12; i++) begin
      IR_Exec = tbl[i].ir_x;
      IR = tbl[i].ir;
      NZP = tbl[i].nzp;
      tick;
      chk($sformatf("vec%0d", i), (BYP || tbl[i].byp == 4'b0) ? 5'b11111 : 5'b00001, 1'b0,
          BYP ? tbl[i].byp : 4'b0000, MS_IDLE);
      IR_Exec = '0;
      IR = '0;
      tick;
      chk($sformatf("vec%0d_after", i), 5'b11111, 1'b0, 4'b0000, MS_IDLE);
    end
    complete_data = 1'b1;
    tick;
    complete_data = 1'b0;
    chk("stray_cd", 5'b11111, 1'b0, 4'b0000, MS_IDLE);
    IR_Exec = 16'h2202;
    tick;
    chk("ld_c1", 5'b00000, 1'b0, 4'b0000, MS_RD);
    tick;
    chk("ld_c2", 5'b00000, 1'b0, 4'b0000, MS_RD);
    tick;
    chk("ld_c3", 5'b00000, 1'b0, 4'b0000, MS_RD);
    complete_data = 1'b1;
    IR_Exec = '0;
    IR = 16'h1442;
    tick;
    complete_data = 1'b0;
    chk("ld_exit", 5'b11111, 1'b0, 4'b0000, MS_IDLE);
    tick;
    chk("ld_fwd", BYP ? 5'b11111 : 5'b00001, 1'b0, BYP ? 4'b0010 : 4'b0000, MS_IDLE);
    IR = '0;
    tick;
    chk("ld_fwd_after", 5'b11111, 1'b0, 4'b0000, MS_IDLE);
    IR_Exec = 16'hB001;
    tick;
    chk("sti_ind1", 5'b00000, 1'b0, 4'b0000, MS_IND);
    tick;
    chk("sti_ind2", 5'b00000, 1'b0, 4'b0000, MS_IND);
    complete_data = 1'b1;
    tick;
    complete_data = 1'b0;
    chk("sti_wr1", 5'b00000, 1'b0, 4'b0000, MS_WR);
    tick;
    chk("sti_wr2", 5'b00000, 1'b0, 4'b0000, MS_WR);
    complete_data = 1'b1;
    IR_Exec = '0;
    tick;
    complete_data = 1'b0;
    chk("sti_exit", 5'b11110, 1'b0, 4'b0000, MS_IDLE);
    tick;
    chk("sti_run", 5'b11111, 1'b0, 4'b0000, MS_IDLE);
    IR_Exec = 16'h0405;
    NZP = 3'b010;
    tick;
    IR_Exec = '0;
    chk("brz_f1", 5'b11001, 1'b1, 4'b0000, MS_IDLE);
    tick;
    chk("brz_f2", 5'b11001, 1'b0, 4'b0000, MS_IDLE);
    tick;
    chk("brz_run", 5'b11111, 1'b0, 4'b0000, MS_IDLE);
    IR_Exec = 16'hC1C0;
    tick;
    IR_Exec = '0;
    chk("jmp_f1", 5'b11001, 1'b1, 4'b0000, MS_IDLE);
    tick; tick;
    chk("jmp_run", 5'b11111, 1'b0, 4'b0000, MS_IDLE);
    IR_Exec = 16'h2202;
    tick;
    complete_data = 1'b1;
    IR_Exec = 16'h0405;
    tick;
    complete_data = 1'b0;
    chk("ldbr_exit", 5'b11111, 1'b0, 4'b0000, MS_IDLE);
    tick;
    IR_Exec = '0;
    chk("ldbr_taken", 5'b11001, 1'b1, 4'b0000, MS_IDLE);
    tick; tick;
    chk("ldbr_run", 5'b11111, 1'b0, 4'b0000, MS_IDLE);
    IR_Exec = 16'h2202;
    tick;
    chk("rst_pre", 5'b00000, 1'b0, 4'b0000, MS_RD);
    #2 reset = 1'b0;
    #1;
    chk("rst_async", 5'b00000, 1'b0, 4'b0000, MS_IDLE);
    IR_Exec = '0;
    reset = 1'b1;
    tick; tick;
    chk("rst_idle", 5'b00000, 1'b0, 4'b0000, MS_IDLE);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
